// File: rtl/shift_normalizer.sv
// Iterative normalizer: shifts a captured word one bit per clock until its leading (dir=0)
// or trailing (dir=1) one reaches the word edge, reporting aligned word, shift count and zero flag.
module shift_normalizer #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned SHAMT_W = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               dir,
   input  logic [WIDTH-1:0]   din,
   output logic [WIDTH-1:0]   dout,
   output logic [SHAMT_W-1:0] shamt,
   output logic               zero,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   sreg;
   logic [SHAMT_W-1:0] count;
   logic               dir_q;
   logic               target_c;

   // Bit that must be set for the word to count as aligned
   assign target_c = dir_q ? sreg[0] : sreg[WIDTH-1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         sreg  <= '0;
         count <= '0;
         dir_q <= 1'b0;
         dout  <= '0;
         shamt <= '0;
         zero  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sreg  <= din;
                  dir_q <= dir;
                  count <= '0;
                  zero  <= 1'b0;
                  busy  <= 1'b1;
                  if (din == '0) begin
                     // Nothing to align: report straight away
                     state <= DONE;
                     dout  <= '0;
                     shamt <= '0;
                     zero  <= 1'b1;
                     done  <= 1'b1;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               if (target_c) begin
                  state <= DONE;
                  dout  <= sreg;
                  shamt <= count;
                  done  <= 1'b1;
               end else begin
                  sreg  <= dir_q ? (sreg >> 1) : (sreg << 1);
                  count <= count + SHAMT_W'(1);
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_normalizer.sv
// Directed and random checks of shift_normalizer against a leading/trailing-zero count model.
module tb_shift_normalizer;

   localparam int unsigned WIDTH   = 8;
   localparam int unsigned SHAMT_W = 3;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic               dir;
   logic [WIDTH-1:0]   din;
   logic [WIDTH-1:0]   dout;
   logic [SHAMT_W-1:0] shamt;
   logic               zero;
   logic               busy;
   logic               done;

   int checks = 0;
   int errors = 0;

   shift_normalizer #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .dir   (dir),
      .din   (din),
      .dout  (dout),
      .shamt (shamt),
      .zero  (zero),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Shift count is the number of zeros in front of the first one seen from the target edge
   function automatic void model(input logic [WIDTH-1:0] d, input logic dr,
                                 output logic [WIDTH-1:0] o, output int k, output logic z);
      logic [WIDTH-1:0] t;
      z = (d == '0);
      k = 0;
      o = '0;
      if (!z) begin
         t = d;
         if (!dr) begin
            while (t[WIDTH-1] == 1'b0) begin t = t << 1; k++; end
            o = WIDTH'(d * (2 ** k));
         end else begin
            while (t[0] == 1'b0) begin t = t >> 1; k++; end
            o = WIDTH'(d / (2 ** k));
         end
      end
   endfunction

   // One operation; glitch_edge>0 drives start with din=FF just before that edge (counted from E0)
   task automatic run_op(input string tag, input logic [WIDTH-1:0] d, input logic dr,
                         input int glitch_edge);
      logic [WIDTH-1:0] exp_o;
      int               exp_k;
      logic             exp_z;
      int               n;
      int               exp_n;
      model(d, dr, exp_o, exp_k, exp_z);
      exp_n = exp_z ? 0 : exp_k + 1;
      start = 1'b1; din = d; dir = dr;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, ":busy_e0"}, 32'(busy), 32'd1);
      n = 0;
      while (!done && n < 40) begin
         if (n + 1 == glitch_edge) begin start = 1'b1; din = 8'hFF; dir = ~dr; end
         @(posedge clk); #1;
         start = 1'b0;
         n++;
      end
      chk({tag, ":latency"}, 32'(n), 32'(exp_n));
      chk({tag, ":dout"}, 32'(dout), 32'(exp_o));
      chk({tag, ":shamt"}, 32'(shamt), 32'(exp_k));
      chk({tag, ":zero"}, 32'(zero), 32'(exp_z));
      chk({tag, ":busy_done"}, 32'(busy), 32'd1);
      @(posedge clk); #1;
      chk({tag, ":done_pulse"}, 32'(done), 32'd0);
      chk({tag, ":busy_idle"}, 32'(busy), 32'd0);
      chk({tag, ":dout_hold"}, 32'(dout), 32'(exp_o));
   endtask

   initial begin
      logic [WIDTH-1:0] rd;
      logic             rdir;
      int               seen_done;
      rst_n = 1'b0; start = 1'b0; dir = 1'b0; din = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset:dout", 32'(dout), 32'd0);
      chk("reset:shamt", 32'(shamt), 32'd0);
      chk("reset:zero", 32'(zero), 32'd0);
      chk("reset:busy", 32'(busy), 32'd0);
      chk("reset:done", 32'(done), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("T1", 8'h13, 1'b0, 0);
      run_op("T2", 8'h28, 1'b1, 0);
      run_op("T3a", 8'h80, 1'b0, 0);
      run_op("T3b", 8'h01, 1'b0, 0);
      run_op("T3c", 8'h01, 1'b1, 0);
      run_op("T3d", 8'h80, 1'b1, 0);
      run_op("T4a", 8'h00, 1'b0, 0);
      run_op("T4b", 8'h00, 1'b1, 0);
      run_op("T5", 8'h01, 1'b0, 3);

      // T6: reset in the middle of an operation
      start = 1'b1; din = 8'h01; dir = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("T6:rst_dout", 32'(dout), 32'd0);
      chk("T6:rst_shamt", 32'(shamt), 32'd0);
      chk("T6:rst_busy", 32'(busy), 32'd0);
      chk("T6:rst_done", 32'(done), 32'd0);
      seen_done = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (done) seen_done++;
      end
      chk("T6:no_done", 32'(seen_done), 32'd0);
      run_op("T6b", 8'h40, 1'b0, 0);

      // Random operations, some back-to-back with the single mandatory idle cycle
      for (int i = 0; i < 40; i++) begin
         rd   = WIDTH'($urandom);
         rdir = 1'($urandom);
         if ($urandom_range(0, 5) == 0) rd = '0;
         run_op("rand", rd, rdir, 0);
         if ($urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
